// File: rtl/dff_pipe_chain.sv
`default_nettype none
// ============================================================================
// Module      : dff_pipe_chain
// Description : Stallable, flushable delay line of DEPTH synchronous-reset
//               stages, each carrying WIDTH data bits plus a valid bit.
//               Outputs come straight from the last stage register.
//               Optional valid-stage occupancy counter on occ_o, present only
//               when the macro DFF_PIPE_OCC_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module dff_pipe_chain #(
    parameter int               WIDTH   = 8,
    parameter int               DEPTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         en_i,
    input  logic                         flush_i,
    input  logic                         valid_i,
    input  logic [WIDTH-1:0]             d_i,
    output logic                         valid_o,
    output logic [WIDTH-1:0]             q_o
`ifdef DFF_PIPE_OCC_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0]   occ_o
`endif
);

    // Stage storage; index 0 is the input stage, DEPTH-1 drives the outputs.
    logic [WIDTH-1:0] r_data  [DEPTH];
    logic [DEPTH-1:0] r_valid;

    // Per-stage source of the next value when the chain advances.
    logic [WIDTH-1:0] w_src_data [DEPTH];
    logic [DEPTH-1:0] w_src_valid;

    assign w_src_data[0]  = d_i;
    assign w_src_valid[0] = valid_i;

    // Stages 1..DEPTH-1 take their predecessor; absent when DEPTH is 1.
    generate
        if (DEPTH > 1) begin : g_link
            for (genvar k = 1; k < DEPTH; k++) begin : g_src
                assign w_src_data[k]  = r_data[k-1];
                assign w_src_valid[k] = r_valid[k-1];
            end
        end
    endgenerate

    generate
        for (genvar k = 0; k < DEPTH; k++) begin : g_stage
            // Data never clears on flush: it shifts on enable, else holds.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_data[k] <= RST_VAL;
                end else if (en_i) begin
                    r_data[k] <= w_src_data[k];
                end
            end

            // Flush kills every valid bit, including the one being loaded.
            always_ff @(posedge clk) begin
                if (reset || flush_i) begin
                    r_valid[k] <= 1'b0;
                end else if (en_i) begin
                    r_valid[k] <= w_src_valid[k];
                end
            end
        end
    endgenerate

    assign valid_o = r_valid[DEPTH-1];
    assign q_o     = r_data[DEPTH-1];

`ifdef DFF_PIPE_OCC_EN
    localparam int c_OCC_W = $clog2(DEPTH+1);

    logic [c_OCC_W-1:0] r_occ;
    logic [c_OCC_W-1:0] w_occ_next;

    // One word enters and the last one leaves on each advance, so the count
    // tracks the popcount of r_valid and stays within 0..DEPTH.
    assign w_occ_next = r_occ + c_OCC_W'(valid_i) - c_OCC_W'(valid_o);

    // Occupancy counter: cleared by reset or flush, updated on advance.
    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            r_occ <= '0;
        end else if (en_i) begin
            r_occ <= w_occ_next;
        end
    end

    assign occ_o = r_occ;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dff_pipe_chain.sv
`default_nettype none
// ============================================================================
// Module      : tb_dff_pipe_chain
// Description : Self-checking bench for dff_pipe_chain. Drives a DEPTH=4 and a
//               DEPTH=1 instance from shared inputs and compares both against
//               a queue-based reference model, plus table vectors and
//               hand-written corner sequences. Occupancy checks are compiled
//               in when DFF_PIPE_OCC_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dff_pipe_chain;

    localparam int         c_W   = 8;
    localparam int         c_D   = 4;
    localparam logic [7:0] c_RST = 8'hA5;

    logic       clk = 1'b0;
    logic       reset, en_i, flush_i, valid_i;
    logic [7:0] d_i;
    logic       v4, v1;
    logic [7:0] q4, q1;
`ifdef DFF_PIPE_OCC_EN
    logic [2:0] occ4;
    logic [0:0] occ1;
`endif

    always #5 clk = ~clk;

    dff_pipe_chain #(.WIDTH(c_W), .DEPTH(c_D), .RST_VAL(c_RST)) u_dut4 (
        .clk(clk), .reset(reset), .en_i(en_i), .flush_i(flush_i),
        .valid_i(valid_i), .d_i(d_i), .valid_o(v4), .q_o(q4)
`ifdef DFF_PIPE_OCC_EN
        , .occ_o(occ4)
`endif
    );

    dff_pipe_chain #(.WIDTH(c_W), .DEPTH(1), .RST_VAL(c_RST)) u_dut1 (
        .clk(clk), .reset(reset), .en_i(en_i), .flush_i(flush_i),
        .valid_i(valid_i), .d_i(d_i), .valid_o(v1), .q_o(q1)
`ifdef DFF_PIPE_OCC_EN
        , .occ_o(occ1)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: a queue of {valid,data} words, front = newest.
    logic [8:0] mq[$];
    logic       m1_v;
    logic [7:0] m1_d;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_occ();
        int n = 0;
        foreach (mq[i]) n += int'(mq[i][8]);
        return n;
    endfunction

    task automatic model_edge();
        if (reset) begin
            mq.delete();
            for (int i = 0; i < c_D; i++) mq.push_back({1'b0, c_RST});
            m1_v = 1'b0;
            m1_d = c_RST;
        end else begin
            if (en_i) begin
                mq.push_front({valid_i, d_i});
                void'(mq.pop_back());
                m1_d = d_i;
                m1_v = valid_i;
            end
            if (flush_i) begin
                foreach (mq[i]) mq[i][8] = 1'b0;
                m1_v = 1'b0;
            end
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_v4"}, 32'(v4), 32'(mq[c_D-1][8]));
        chk({tag, "_q4"}, 32'(q4), 32'(mq[c_D-1][7:0]));
        chk({tag, "_v1"}, 32'(v1), 32'(m1_v));
        chk({tag, "_q1"}, 32'(q1), 32'(m1_d));
`ifdef DFF_PIPE_OCC_EN
        chk({tag, "_occ4"}, 32'(occ4), 32'(model_occ()));
        chk({tag, "_occ1"}, 32'(occ1), 32'(m1_v));
`endif
    endtask

    // Apply one edge of stimulus, advance the model, then sample off-edge.
    task automatic step(input logic r, input logic e, input logic f,
                        input logic v, input logic [7:0] d, input string tag);
        reset = r; en_i = e; flush_i = f; valid_i = v; d_i = d;
        @(posedge clk);
        model_edge();
        #1;
        check_model(tag);
    endtask

    typedef struct {
        logic       rst, en, fl, v;
        logic [7:0] d;
        logic       ev;
        logic [7:0] eq;
        logic [2:0] eocc;
    } vec_t;

    vec_t tbl[11];

    initial begin
        logic       sv_v;
        logic [7:0] sv_q;
`ifdef DFF_PIPE_OCC_EN
        logic [2:0] sv_o;
`endif
        reset = 1'b1; en_i = 1'b0; flush_i = 1'b0; valid_i = 1'b0; d_i = 8'h00;
        for (int i = 0; i < c_D; i++) mq.push_back({1'b0, c_RST});
        m1_v = 1'b0; m1_d = c_RST;

        // Reset for two edges (second with en/valid asserted), then stream 01..04.
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'hA5, 3'd0};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h33, 1'b0, 8'hA5, 3'd0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'hA5, 3'd0};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h01, 1'b0, 8'hA5, 3'd1};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h02, 1'b0, 8'hA5, 3'd2};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h03, 1'b0, 8'hA5, 3'd3};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h04, 1'b1, 8'h01, 3'd4};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h02, 3'd3};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h03, 3'd2};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h04, 3'd1};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 3'd0};

        for (int i = 0; i < 11; i++) begin
            step(tbl[i].rst, tbl[i].en, tbl[i].fl, tbl[i].v, tbl[i].d, "tbl");
            chk($sformatf("tbl%0d_v", i), 32'(v4), 32'(tbl[i].ev));
            chk($sformatf("tbl%0d_q", i), 32'(q4), 32'(tbl[i].eq));
`ifdef DFF_PIPE_OCC_EN
            chk($sformatf("tbl%0d_occ", i), 32'(occ4), 32'(tbl[i].eocc));
`endif
        end

        // Stall: two words in, three held cycles, two more words in.
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, "t3");
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'h10, "t3");
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'h11, "t3");
        sv_v = v4; sv_q = q4;
`ifdef DFF_PIPE_OCC_EN
        sv_o = occ4;
`endif
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'($urandom), 8'($urandom), "t3s");
            chk("t3_frozen_v", 32'(v4), 32'(sv_v));
            chk("t3_frozen_q", 32'(q4), 32'(sv_q));
`ifdef DFF_PIPE_OCC_EN
            chk("t3_frozen_occ", 32'(occ4), 32'(sv_o));
`endif
        end
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'h12, "t3");
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'h13, "t3");
        chk("t3_emerge_q", 32'(q4), 32'h10);
        chk("t3_emerge_v", 32'(v4), 32'h1);

        // Flush with a valid incoming word: all valids clear, data still shifts.
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, "t4");
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b1, 8'(8'h40 + i), "t4");
        chk("t4_full_q", 32'(q4), 32'h40);
        step(1'b0, 1'b1, 1'b1, 1'b1, 8'hFF, "t4f");
        chk("t4_flush_v", 32'(v4), 32'h0);
`ifdef DFF_PIPE_OCC_EN
        chk("t4_flush_occ", 32'(occ4), 32'h0);
`endif
        for (int i = 1; i < 4; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, "t4");
            chk("t4_after_v", 32'(v4), 32'h0);
        end
        chk("t4_ff_q", 32'(q4), 32'hFF);

        // Reset mid-stream with enable high, then one word after release.
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, "t5");
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b1, 8'(8'h20 + i), "t5");
        step(1'b1, 1'b1, 1'b0, 1'b1, 8'h55, "t5r");
        chk("t5_rst_q", 32'(q4), 32'hA5);
        chk("t5_rst_v", 32'(v4), 32'h0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'h30, "t5");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, "t5");
        chk("t5_word_q", 32'(q4), 32'h30);
        chk("t5_word_v", 32'(v4), 32'h1);

        // Randomized traffic with stalls, flushes and occasional resets.
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 50) == 0, ($urandom % 4) != 0, ($urandom % 16) == 0,
                 1'($urandom), 8'($urandom), "rnd");
        end

        // DEPTH=1 instance: alternating valid with random enable.
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, "t6");
        for (int i = 0; i < 50; i++) begin
            step(1'b0, 1'($urandom), 1'b0, 1'(i % 2 == 0), 8'($urandom), "t6");
`ifdef DFF_PIPE_OCC_EN
            chk("t6_occ_eq_v", 32'(occ1), 32'(v1));
`endif
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
